// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite definitions: response codes, per-path state encodings and
// the address range helper used by the responder.
package axi_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_RESP
    } r_state_e;

    // A byte address is decoded only if every bit above the word index is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned mwidth);
        return (addr >> (mwidth + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/bram_be.sv
// Byte-enabled synchronous RAM with one write port and one read port;
// a same-cycle read and write of one word returns the old contents.
module bram_be #(
    parameter int MWIDTH    = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [MWIDTH-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              re_i,
    input  logic [MWIDTH-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    localparam int DEPTH = 2 ** MWIDTH;

    // NOTE: storage has no reset; only its elaboration-time contents are defined.
    logic [31:0] mem_q [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};
    logic [31:0] rdata_q;

    // NOTE: non-blocking assignments make the read sample the pre-write word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i && wstrb_i[i]) begin
                mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-lite responder backed by a byte-enabled RAM; write and read paths are
// independent FSMs, each allowing one outstanding transaction.
module axi_lite_slave_mem
    import axi_lite_pkg::*;
#(
    parameter int MWIDTH    = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp
);

    w_state_e          w_state_q;
    logic              aw_held_q, w_held_q, aw_ok_q;
    logic [MWIDTH-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q;

    r_state_e          r_state_q;
    logic [MWIDTH-1:0] raddr_q;
    logic [1:0]        rresp_q;
    logic [31:0]       ram_rdata;

    logic aw_hs, w_hs, ar_hs, commit, mem_we;

    // prot and the byte offset inside a word carry no meaning for this memory.
    logic unused_bits;
    assign unused_bits = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

    assign axi_awready = (w_state_q == W_IDLE) && !aw_held_q && !rst;
    assign axi_wready  = (w_state_q == W_IDLE) && !w_held_q && !rst;
    assign axi_bvalid  = (w_state_q == W_RESP) && !rst;
    assign axi_bresp   = bresp_q;

    assign aw_hs  = axi_awvalid && axi_awready;
    assign w_hs   = axi_wvalid && axi_wready;
    assign commit = (w_state_q == W_IDLE) && aw_held_q && w_held_q;
    assign mem_we = commit && aw_ok_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_ok_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        aw_ok_q   <= addr_in_range(axi_awaddr, MWIDTH);
                        waddr_q   <= axi_awaddr[MWIDTH+1:2];
                    end
                    if (w_hs) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= axi_wdata;
                        wstrb_q  <= axi_wstrb;
                    end
                    if (commit) begin
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        bresp_q   <= aw_ok_q ? OKAY : DECERR;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign axi_arready = (r_state_q == R_IDLE) && !rst;
    assign axi_rvalid  = (r_state_q == R_RESP) && !rst;
    assign axi_rresp   = rresp_q;
    // Out-of-range reads and the idle/reset state present zero data.
    assign axi_rdata   = (axi_rvalid && rresp_q == OKAY) ? ram_rdata : 32'h0;
    assign ar_hs       = axi_arvalid && axi_arready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        raddr_q   <= axi_araddr[MWIDTH+1:2];
                        rresp_q   <= addr_in_range(axi_araddr, MWIDTH) ? OKAY : DECERR;
                        r_state_q <= R_READ;
                    end
                end
                R_READ: r_state_q <= R_RESP;
                R_RESP: begin
                    if (axi_rready) begin
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    bram_be #(
        .MWIDTH   (MWIDTH),
        .INIT_ZERO(INIT_ZERO)
    ) u_ram (
        .clk    (clk),
        .we_i   (mem_we),
        .waddr_i(waddr_q),
        .wdata_i(wdata_q),
        .wstrb_i(wstrb_q),
        .re_i   (r_state_q == R_READ),
        .raddr_i(raddr_q),
        .rdata_o(ram_rdata)
    );

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Scoreboard bench for axi_lite_slave_mem: directed scenarios plus random
// traffic checked against an array model of the word memory.
module tb_axi_lite_slave_mem;

    localparam int MW    = 10;
    localparam int DEPTH = 2 ** MW;
    localparam int TO    = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_wvalid, axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid, axi_arready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;

    axi_lite_slave_mem #(.MWIDTH(MW), .INIT_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic [1:0]  b_exp [$];
    r_exp_t      r_exp [$];
    logic [31:0] ref_mem [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          bp_mode = 0;  // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Reference model: plain byte-lane update on an array of words.
    function automatic bit in_range(input logic [31:0] a);
        return (a >> (MW + 2)) == 0;
    endfunction

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'((a >> 2) % DEPTH);
        if (in_range(a)) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
            b_exp.push_back(2'b00);
        end else begin
            b_exp.push_back(2'b11);
        end
    endtask

    task automatic expect_read(input logic [31:0] a);
        r_exp_t e;
        if (in_range(a)) begin
            e.data = ref_mem[int'((a >> 2) % DEPTH)];
            e.resp = 2'b00;
        end else begin
            e.data = 32'h0;
            e.resp = 2'b11;
        end
        r_exp.push_back(e);
    endtask

    task automatic do_aw(input logic [31:0] a);
        @(posedge clk); #1;
        axi_awvalid = 1'b1; axi_awaddr = a; axi_awprot = 3'($urandom);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            if (axi_awready) begin
                @(posedge clk); #1;
                axi_awvalid = 1'b0;
                return;
            end
        end
        timeout_fail("aw_handshake");
        axi_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        axi_wvalid = 1'b1; axi_wdata = d; axi_wstrb = s;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            if (axi_wready) begin
                @(posedge clk); #1;
                axi_wvalid = 1'b0;
                return;
            end
        end
        timeout_fail("w_handshake");
        axi_wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a);
        @(posedge clk); #1;
        axi_arvalid = 1'b1; axi_araddr = a; axi_arprot = 3'($urandom);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            if (axi_arready) begin
                @(posedge clk); #1;
                axi_arvalid = 1'b0;
                return;
            end
        end
        timeout_fail("ar_handshake");
        axi_arvalid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < TO; i++) begin
            if (b_exp.size() == 0 && r_exp.size() == 0) return;
            @(negedge clk);
        end
        timeout_fail("response_drain");
        b_exp.delete();
        r_exp.delete();
    endtask

    // Number of falling edges after a handshake until the chosen valid rises.
    task automatic valid_latency(input bit is_b, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((is_b && axi_bvalid) || (!is_b && axi_rvalid)) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        expect_write(a, d, s);
        fork
            do_aw(a);
            do_w(d, s);
        join
        wait_drain();
    endtask

    task automatic read_txn(input logic [31:0] a);
        expect_read(a);
        do_ar(a);
        wait_drain();
    endtask

    // Response ready generation.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0: begin axi_bready = 1'b1; axi_rready = 1'b1; end
            1: begin axi_bready = 1'($urandom); axi_rready = 1'($urandom); end
            default: begin axi_bready = 1'b0; axi_rready = 1'b0; end
        endcase
    end

    // Monitor: pops the scoreboard on every response handshake and checks
    // that stalled responses hold steady and block new requests.
    logic        prev_rst = 1'b1;
    logic        prev_b_stall = 1'b0, prev_r_stall = 1'b0;
    logic [1:0]  prev_bresp, prev_rresp;
    logic [31:0] prev_rdata;

    always @(negedge clk) begin
        if (!rst) begin
            if (axi_bvalid) begin
                check("awready_while_bvalid", 32'(axi_awready), 32'd0);
                check("wready_while_bvalid", 32'(axi_wready), 32'd0);
            end
            if (axi_rvalid) check("arready_while_rvalid", 32'(axi_arready), 32'd0);
            if (!prev_rst && prev_b_stall) begin
                check("bvalid_hold", 32'(axi_bvalid), 32'd1);
                check("bresp_hold", 32'(axi_bresp), 32'(prev_bresp));
            end
            if (!prev_rst && prev_r_stall) begin
                check("rvalid_hold", 32'(axi_rvalid), 32'd1);
                check("rresp_hold", 32'(axi_rresp), 32'(prev_rresp));
                check("rdata_hold", axi_rdata, prev_rdata);
            end
            if (axi_bvalid && axi_bready) begin
                if (b_exp.size() == 0) timeout_fail("unexpected_b");
                else check("bresp", 32'(axi_bresp), 32'(b_exp.pop_front()));
            end
            if (axi_rvalid && axi_rready) begin
                if (r_exp.size() == 0) begin
                    timeout_fail("unexpected_r");
                end else begin
                    r_exp_t e;
                    e = r_exp.pop_front();
                    check("rdata", axi_rdata, e.data);
                    check("rresp", 32'(axi_rresp), 32'(e.resp));
                end
            end
        end
        prev_rst     = rst;
        prev_b_stall = axi_bvalid && !axi_bready;
        prev_r_stall = axi_rvalid && !axi_rready;
        prev_bresp   = axi_bresp;
        prev_rresp   = axi_rresp;
        prev_rdata   = axi_rdata;
    end

    function automatic logic [31:0] pick_addr();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return $urandom | 32'h0000_1000;
        if (sel == 1) return 32'((DEPTH - 1 - $urandom_range(0, 3)) * 4 + $urandom_range(0, 3));
        return 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
    endfunction

    initial begin
        int          lat;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          d1, d2;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        rst = 1'b1;
        axi_awvalid = 1'b0; axi_awaddr = '0; axi_awprot = '0;
        axi_wvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0;
        axi_arvalid = 1'b0; axi_araddr = '0; axi_arprot = '0;
        axi_bready = 1'b1; axi_rready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(axi_awready), 32'd0);
        check("rst_wready", 32'(axi_wready), 32'd0);
        check("rst_arready", 32'(axi_arready), 32'd0);
        check("rst_bvalid", 32'(axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(axi_rvalid), 32'd0);
        check("rst_bresp", 32'(axi_bresp), 32'd0);
        check("rst_rresp", 32'(axi_rresp), 32'd0);
        check("rst_rdata", axi_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_awready", 32'(axi_awready), 32'd1);
        check("idle_wready", 32'(axi_wready), 32'd1);
        check("idle_arready", 32'(axi_arready), 32'd1);

        // Simultaneous AW/W, then read back, with latency checks.
        expect_write(32'h10, 32'hDEADBEEF, 4'hF);
        fork
            do_aw(32'h10);
            do_w(32'hDEADBEEF, 4'hF);
        join
        valid_latency(1'b1, lat);
        check("b_latency", 32'(lat), 32'd2);
        wait_drain();
        expect_read(32'h10);
        do_ar(32'h10);
        valid_latency(1'b0, lat);
        check("r_latency", 32'(lat), 32'd2);
        wait_drain();

        // W three cycles ahead of AW.
        expect_write(32'h4, 32'h11223344, 4'hF);
        do_w(32'h11223344, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wready_after_w", 32'(axi_wready), 32'd0);
            check("no_b_before_aw", 32'(axi_bvalid), 32'd0);
        end
        do_aw(32'h4);
        wait_drain();
        read_txn(32'h4);

        // Partial strobes and an empty strobe.
        write_txn(32'h8, 32'hFFFFFFFF, 4'hF);
        write_txn(32'h8, 32'hAABBCCDD, 4'b0101);
        check("strb_model", ref_mem[2], 32'hFFBBFFDD);
        read_txn(32'h8);
        write_txn(32'h8, 32'h12345678, 4'h0);
        read_txn(32'h8);

        // Out-of-range access leaves word 0 alone.
        write_txn(32'h0, 32'hCAFEF00D, 4'hF);
        write_txn(32'h1000, 32'h55555555, 4'hF);
        read_txn(32'h1000);
        read_txn(32'h0);

        // Commit and read of the same word at the same edge returns old data.
        expect_read(32'h10);
        expect_write(32'h10, 32'h0BADCAFE, 4'hF);
        fork
            do_aw(32'h10);
            do_w(32'h0BADCAFE, 4'hF);
            do_ar(32'h10);
        join
        wait_drain();
        read_txn(32'h10);

        // Back-pressure: responses stall for several cycles.
        bp_mode = 2;
        expect_write(32'h14, 32'h01020304, 4'hF);
        expect_read(32'h4);
        fork
            do_aw(32'h14);
            do_w(32'h01020304, 4'hF);
            do_ar(32'h4);
        join
        repeat (6) @(negedge clk);
        check("stall_bvalid", 32'(axi_bvalid), 32'd1);
        check("stall_rvalid", 32'(axi_rvalid), 32'd1);
        bp_mode = 0;
        wait_drain();

        // Reset while both responses are pending.
        bp_mode = 2;
        expect_write(32'h20, 32'h87654321, 4'hF);
        fork
            do_aw(32'h20);
            do_w(32'h87654321, 4'hF);
            do_ar(32'h10);
        join
        repeat (3) @(negedge clk);
        check("pre_rst_bvalid", 32'(axi_bvalid), 32'd1);
        check("pre_rst_rvalid", 32'(axi_rvalid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("in_rst_bvalid", 32'(axi_bvalid), 32'd0);
        check("in_rst_rvalid", 32'(axi_rvalid), 32'd0);
        check("in_rst_awready", 32'(axi_awready), 32'd0);
        check("in_rst_arready", 32'(axi_arready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        b_exp.delete();
        r_exp.delete();
        bp_mode = 0;
        @(negedge clk);
        check("post_rst_bvalid", 32'(axi_bvalid), 32'd0);
        check("post_rst_rvalid", 32'(axi_rvalid), 32'd0);
        check("post_rst_awready", 32'(axi_awready), 32'd1);
        check("post_rst_wready", 32'(axi_wready), 32'd1);
        check("post_rst_arready", 32'(axi_arready), 32'd1);
        read_txn(32'h20);
        read_txn(32'h10);
        read_txn(32'h8);

        // Random traffic with AW/W skew and random response back-pressure.
        bp_mode = 1;
        for (int t = 0; t < 300; t++) begin
            a = pick_addr();
            if ($urandom_range(0, 1) == 1) begin
                d  = $urandom;
                s  = 4'($urandom);
                d1 = $urandom_range(0, 3);
                d2 = $urandom_range(0, 3);
                expect_write(a, d, s);
                fork
                    begin repeat (d1) @(posedge clk); do_aw(a); end
                    begin repeat (d2) @(posedge clk); do_w(d, s); end
                join
            end else begin
                expect_read(a);
                do_ar(a);
            end
            wait_drain();
        end
        bp_mode = 0;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
